mem_access_stage: RTL and testbench

//  Memory stage directly downstream of the execute/ALU buffer in the filter GPU pipeline; fed by ALUResultM, A2M, A3M, WriteDataM.

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - 3-lane vector load/store serialiser with MEM/WB register
//
// Purpose:
//    Sits behind the execute buffer. A vector load or store is serialised onto
//    one single-port data RAM, one lane per cycle, in lane order 0,1,2. StallM
//    holds the upstream stages while an access is in flight. The stage also
//    holds the MEM/WB pipeline register.
//
// Ports:
//    CLK, RST               clock, synchronous active-high reset
//    MemWriteM, MemtoRegM   vector store / vector load in M (store wins if both set)
//    RegWriteM, WA3M        register write enable and destination, forwarded to W
//    ALUResultM             lane results; lane0 address is ALUResultM[0][ADDR_W-1:0]
//    A2M, A3M               lane1 / lane2 addresses
//    WriteDataM             store data, lane k goes to address k
//    mem_rdata              RAM read data, valid the cycle after its address
//    mem_addr/wdata/we      registered RAM request
//    StallM                 combinational hold request to the hazard unit
//    ReadDataW, ALUOutW,
//    WA3W, RegWriteW,
//    MemtoRegW              registered W-stage outputs

module mem_access_stage #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10,
   parameter int WA_W   = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   MemWriteM,
   input  logic                   MemtoRegM,
   input  logic                   RegWriteM,
   input  logic [WA_W-1:0]        WA3M,
   input  logic [2:0][DATA_W-1:0] ALUResultM,
   input  logic [ADDR_W-1:0]      A2M,
   input  logic [ADDR_W-1:0]      A3M,
   input  logic [2:0][DATA_W-1:0] WriteDataM,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_we,
   output logic                   StallM,
   output logic [2:0][DATA_W-1:0] ReadDataW,
   output logic [2:0][DATA_W-1:0] ALUOutW,
   output logic [WA_W-1:0]        WA3W,
   output logic                   RegWriteW,
   output logic                   MemtoRegW
);

   typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

   state_t                   state_q,       state_d;
   logic [1:0]               cnt_q,         cnt_d;
   logic                     is_store_q,    is_store_d;
   logic [2:0][ADDR_W-1:0]   addr_q,        addr_d;
   logic [2:0][DATA_W-1:0]   wdata_q,       wdata_d;
   logic [2:0][DATA_W-1:0]   rdbuf_q,       rdbuf_d;
   logic [ADDR_W-1:0]        mem_addr_q,    mem_addr_d;
   logic [DATA_W-1:0]        mem_wdata_q,   mem_wdata_d;
   logic                     mem_we_q,      mem_we_d;
   logic [2:0][DATA_W-1:0]   read_data_w_q, read_data_w_d;
   logic [2:0][DATA_W-1:0]   alu_out_w_q,   alu_out_w_d;
   logic [WA_W-1:0]          wa3_w_q,       wa3_w_d;
   logic                     reg_write_w_q, reg_write_w_d;
   logic                     memto_reg_w_q, memto_reg_w_d;

   logic                     mem_op;

   assign mem_op = MemWriteM | MemtoRegM;

   // The stall must be visible in the same cycle the op arrives in IDLE so the
   // hazard unit freezes M before the next edge.
   assign StallM = ((state_q == IDLE) && mem_op) || (state_q == ACC) || (state_q == WAIT);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_store_d    = is_store_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdbuf_d       = rdbuf_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = 1'b0;
      read_data_w_d = read_data_w_q;
      alu_out_w_d   = alu_out_w_q;
      wa3_w_d       = wa3_w_q;
      reg_write_w_d = reg_write_w_q;
      memto_reg_w_d = memto_reg_w_q;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               is_store_d  = MemWriteM;
               addr_d      = {A3M, A2M, ALUResultM[0][ADDR_W-1:0]};
               wdata_d     = WriteDataM;
               cnt_d       = 2'd0;
               // Lane 0 request is set up here so it is on the RAM port for the
               // whole of the first ACC cycle.
               mem_addr_d  = ALUResultM[0][ADDR_W-1:0];
               mem_wdata_d = WriteDataM[0];
               mem_we_d    = MemWriteM;
               state_d     = ACC;
            end else begin
               read_data_w_d = '0;
               alu_out_w_d   = ALUResultM;
               wa3_w_d       = WA3M;
               reg_write_w_d = RegWriteM;
               memto_reg_w_d = MemtoRegM;
            end
         end

         ACC: begin
            // RAM data trails the address by one cycle, so lane cnt-1 lands now.
            if (!is_store_q && (cnt_q != 2'd0)) begin
               rdbuf_d[cnt_q - 2'd1] = mem_rdata;
            end
            if (cnt_q == 2'd2) begin
               cnt_d   = 2'd0;
               state_d = is_store_q ? DONE : WAIT;
            end else begin
               cnt_d       = cnt_q + 2'd1;
               mem_addr_d  = addr_q[cnt_q + 2'd1];
               mem_wdata_d = wdata_q[cnt_q + 2'd1];
               mem_we_d    = is_store_q;
            end
         end

         WAIT: begin
            rdbuf_d[2] = mem_rdata;
            state_d    = DONE;
         end

         DONE: begin
            // M inputs are still held by the hazard unit through this cycle.
            read_data_w_d = is_store_q ? '0 : rdbuf_q;
            alu_out_w_d   = ALUResultM;
            wa3_w_d       = WA3M;
            reg_write_w_d = RegWriteM;
            memto_reg_w_d = MemtoRegM;
            state_d       = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         is_store_q    <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdbuf_q       <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         read_data_w_q <= '0;
         alu_out_w_q   <= '0;
         wa3_w_q       <= '0;
         reg_write_w_q <= 1'b0;
         memto_reg_w_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_store_q    <= is_store_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdbuf_q       <= rdbuf_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         read_data_w_q <= read_data_w_d;
         alu_out_w_q   <= alu_out_w_d;
         wa3_w_q       <= wa3_w_d;
         reg_write_w_q <= reg_write_w_d;
         memto_reg_w_q <= memto_reg_w_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign ReadDataW = read_data_w_q;
   assign ALUOutW   = alu_out_w_q;
   assign WA3W      = wa3_w_q;
   assign RegWriteW = reg_write_w_q;
   assign MemtoRegW = memto_reg_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage

module tb_mem_access_stage;

   localparam int DW = 18;
   localparam int AW = 10;
   localparam int WW = 4;

   logic                 clk = 1'b0;
   logic                 RST;
   logic                 MemWriteM, MemtoRegM, RegWriteM;
   logic [WW-1:0]        WA3M;
   logic [2:0][DW-1:0]   ALUResultM;
   logic [AW-1:0]        A2M, A3M;
   logic [2:0][DW-1:0]   WriteDataM;
   logic [DW-1:0]        mem_rdata;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_wdata;
   logic                 mem_we;
   logic                 StallM;
   logic [2:0][DW-1:0]   ReadDataW, ALUOutW;
   logic [WW-1:0]        WA3W;
   logic                 RegWriteW, MemtoRegW;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .CLK        (clk),
      .RST        (RST),
      .MemWriteM  (MemWriteM),
      .MemtoRegM  (MemtoRegM),
      .RegWriteM  (RegWriteM),
      .WA3M       (WA3M),
      .ALUResultM (ALUResultM),
      .A2M        (A2M),
      .A3M        (A3M),
      .WriteDataM (WriteDataM),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .StallM     (StallM),
      .ReadDataW  (ReadDataW),
      .ALUOutW    (ALUOutW),
      .WA3W       (WA3W),
      .RegWriteW  (RegWriteW),
      .MemtoRegW  (MemtoRegW)
   );

   // Single-port RAM, 1-cycle read latency, read-before-write.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic          ram_clr;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
         mem_rdata <= '0;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      int                 stall;
      logic [2:0][DW-1:0] rd;
      logic [2:0][DW-1:0] alu;
      logic [WW-1:0]      wa3;
      logic               rw;
      logic               mtr;
   } wb_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wb_t  wb_q[$];
   wr_t  wr_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic instr_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      wr_q.push_back(w);
   endtask

   // W-stage monitor: an instruction retires on the edge after a cycle in which
   // it was in M with StallM low; its W outputs are compared one half-cycle later.
   initial begin : w_monitor
      logic pend;
      int   stall_cnt;
      int   pend_stall;
      wb_t  e;
      pend       = 1'b0;
      stall_cnt  = 0;
      pend_stall = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (wb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wb_unexpected actual=retire required=none");
            end else begin
               e = wb_q.pop_front();
               chk("stall_len",  pend_stall, e.stall);
               chk("ReadDataW",  ReadDataW,  e.rd);
               chk("ALUOutW",    ALUOutW,    e.alu);
               chk("WA3W",       WA3W,       e.wa3);
               chk("RegWriteW",  RegWriteW,  e.rw);
               chk("MemtoRegW",  MemtoRegW,  e.mtr);
            end
         end
         pend = 1'b0;
         if (!instr_valid) begin
            stall_cnt = 0;
         end else if (StallM) begin
            stall_cnt++;
         end else begin
            pend       = 1'b1;
            pend_stall = stall_cnt;
            stall_cnt  = 0;
         end
      end
   end

   // RAM write monitor.
   initial begin : wr_monitor
      wr_t w;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wr_unexpected actual=%0h:%0h required=none", mem_addr, mem_wdata);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", mem_addr,  w.a);
               chk("wr_data", mem_wdata, w.d);
            end
         end
      end
   end

   task automatic drive(input logic mw, input logic mtr, input logic rw, input logic [WW-1:0] wa3,
                        input logic [2:0][DW-1:0] alu, input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [2:0][DW-1:0] wd);
      MemWriteM  = mw;
      MemtoRegM  = mtr;
      RegWriteM  = rw;
      WA3M       = wa3;
      ALUResultM = alu;
      A2M        = a2;
      A3M        = a3;
      WriteDataM = wd;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
   endtask

   // Called just after a rising edge; returns just after the retiring edge.
   task automatic issue(input logic mw, input logic mtr, input logic rw, input logic [WW-1:0] wa3,
                        input logic [2:0][DW-1:0] alu, input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [2:0][DW-1:0] wd, input logic [2:0][DW-1:0] exp_rd, input int exp_stall);
      wb_t e;
      int  n;
      e.stall = exp_stall;
      e.rd    = exp_rd;
      e.alu   = alu;
      e.wa3   = wa3;
      e.rw    = rw;
      e.mtr   = mtr;
      wb_q.push_back(e);
      drive(mw, mtr, rw, wa3, alu, a2, a3, wd);
      instr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (StallM && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (StallM) begin
         checks++;
         failures++;
         $display("FAIL stall_timeout actual=%0d required=<20", n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      RST     = 1'b1;
      ram_clr = 1'b1;
      nop();
      repeat (3) @(posedge clk);
      #1;
      RST     = 1'b0;
      ram_clr = 1'b0;
      @(negedge clk);
      chk("rst_StallM",    StallM,    1'b0);
      chk("rst_mem_we",    mem_we,    1'b0);
      chk("rst_mem_addr",  mem_addr,  '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_ReadDataW", ReadDataW, '0);
      chk("rst_ALUOutW",   ALUOutW,   '0);
      chk("rst_RegWriteW", RegWriteW, 1'b0);
      @(posedge clk);
      #1;

      // 1: store {0x11,0x22,0x33} to {5,6,7}
      exp_wr(10'd5, 18'h00011);
      exp_wr(10'd6, 18'h00022);
      exp_wr(10'd7, 18'h00033);
      issue(1'b1, 1'b0, 1'b0, 4'd1, {18'h00200, 18'h00100, 18'h00005}, 10'd6, 10'd7,
            {18'h00033, 18'h00022, 18'h00011}, '0, 4);
      chk("ram6", ram[6], 18'h00022);

      // 2: load back from {5,6,7}
      issue(1'b0, 1'b1, 1'b1, 4'd3, {18'h0, 18'h0, 18'h00005}, 10'd6, 10'd7, '0,
            {18'h00033, 18'h00022, 18'h00011}, 5);

      // 3: non-memory op
      issue(1'b0, 1'b0, 1'b1, 4'd5, {18'h0, 18'h0, 18'h2ABCD}, 10'd0, 10'd0, '0, '0, 0);

      // 4: all lanes to addr 9; MemtoRegM also set, store must win
      exp_wr(10'd9, 18'd1);
      exp_wr(10'd9, 18'd2);
      exp_wr(10'd9, 18'd3);
      issue(1'b1, 1'b1, 1'b0, 4'd2, {18'h0, 18'h0, 18'h00009}, 10'd9, 10'd9,
            {18'd3, 18'd2, 18'd1}, '0, 4);
      chk("ram9", ram[9], 18'd3);
      issue(1'b0, 1'b1, 1'b1, 4'd7, {18'h0, 18'h0, 18'h00009}, 10'd9, 10'd9, '0,
            {18'd3, 18'd2, 18'd1} & '0 | {18'd3, 18'd3, 18'd3}, 5);
      instr_valid = 1'b0;
      nop();
      @(posedge clk);
      #1;

      // 5: reset while lane 1 of a store is on the RAM port
      exp_wr(10'd20, 18'h0000A);
      exp_wr(10'd21, 18'h0000B);
      drive(1'b1, 1'b0, 1'b0, 4'd4, {18'h0, 18'h0, 18'd20}, 10'd21, 10'd22,
            {18'h0000C, 18'h0000B, 18'h0000A});
      @(negedge clk);
      chk("r5_stall_idle", StallM, 1'b1);
      @(negedge clk);
      chk("r5_lane0_addr", mem_addr, 10'd20);
      @(negedge clk);
      chk("r5_lane1_addr", mem_addr, 10'd21);
      chk("r5_lane1_we",   mem_we,   1'b1);
      #1;
      RST = 1'b1;
      @(posedge clk);
      #1;
      RST = 1'b0;
      nop();
      @(negedge clk);
      chk("r5_StallM",    StallM,    1'b0);
      chk("r5_mem_we",    mem_we,    1'b0);
      chk("r5_mem_addr",  mem_addr,  '0);
      chk("r5_ReadDataW", ReadDataW, '0);
      chk("r5_ALUOutW",   ALUOutW,   '0);
      chk("r5_WA3W",      WA3W,      '0);
      repeat (5) @(negedge clk);
      chk("r5_ram21", ram[21], 18'h0000B);
      chk("r5_ram22", ram[22], 18'h0);
      @(posedge clk);
      #1;

      // 6: store at 0x3FF (upper ALU bits ignored), then load back-to-back
      exp_wr(10'h3FF, 18'h3AAAA);
      exp_wr(10'h000, 18'h15555);
      exp_wr(10'h001, 18'h00077);
      issue(1'b1, 1'b0, 1'b0, 4'd6, {18'h0, 18'h0, 18'h3FFFF}, 10'h000, 10'h001,
            {18'h00077, 18'h15555, 18'h3AAAA}, '0, 4);
      issue(1'b0, 1'b1, 1'b1, 4'd8, {18'h0, 18'h0, 18'h3FFFF}, 10'h000, 10'h001, '0,
            {18'h00077, 18'h15555, 18'h3AAAA}, 5);
      instr_valid = 1'b0;
      nop();

      repeat (4) @(negedge clk);
      chk("wr_queue_empty", wr_q.size(), 0);
      chk("wb_queue_empty", wb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=expired required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule
